// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [1:0] FETCH_MASKMODE = 2'b10;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Cycle counter for an outstanding memory transaction; expire flags the last allowed cycle.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable)  cnt <= cnt + 8'd1;
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one req/ack memory port between instruction fetch and load/store.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [1:0]            d_maskmode,
  input  logic                  d_sext,
  output logic                  d_ready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_maskmode,
  output logic                  mem_sext,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t state, state_n;
  owner_t owner, last_grant, grant_own;
  logic   grant, done, expire, wd_en;
  logic [DATA_WIDTH-1:0] resp_data;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk   (clk),
    .rst   (rst),
    .clear (grant),
    .enable(wd_en),
    .expire(expire)
  );

  always_comb begin
    state_n   = state;
    grant     = 1'b0;
    grant_own = OWN_IF;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (if_req || d_req) begin
          grant = 1'b1;
          // On a tie the side that did not win last time goes next.
          if (if_req && d_req) grant_own = (last_grant == OWN_IF) ? OWN_D : OWN_IF;
          else                 grant_own = d_req ? OWN_D : OWN_IF;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack || expire) begin
          done    = 1'b1;
          state_n = ST_RESP;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign wd_en     = (state == ST_BUSY) && !mem_ack;
  assign resp_data = (mem_ack && !mem_we) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner        <= OWN_IF;
      last_grant   <= OWN_IF;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_maskmode <= '0;
      mem_sext     <= 1'b0;
      if_rdata     <= '0;
      if_err       <= 1'b0;
      d_rdata      <= '0;
      d_err        <= 1'b0;
    end else begin
      state <= state_n;
      if (grant) begin
        owner      <= grant_own;
        last_grant <= grant_own;
        if (grant_own == OWN_D) begin
          mem_we       <= d_we;
          mem_addr     <= d_addr;
          mem_wdata    <= d_wdata;
          mem_maskmode <= d_maskmode;
          mem_sext     <= d_sext;
        end else begin
          mem_we       <= 1'b0;
          mem_addr     <= if_addr;
          mem_wdata    <= '0;
          mem_maskmode <= FETCH_MASKMODE;
          mem_sext     <= 1'b0;
        end
      end
      // An ack arriving in the expiry cycle still completes normally.
      if (done) begin
        if (owner == OWN_D) begin
          d_rdata <= resp_data;
          d_err   <= !mem_ack;
        end else begin
          if_rdata <= resp_data;
          if_err   <= !mem_ack;
        end
      end
    end
  end

  assign mem_req  = (state == ST_BUSY);
  assign if_ready = (state == ST_RESP) && (owner == OWN_IF);
  assign d_ready  = (state == ST_RESP) && (owner == OWN_D);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one unified memory port between the instruction-fetch path and the load/store (data) path of the multi-cycle RV32I core. It accepts level-held requests from each side, grants one at a time with round-robin fairness on ties, drives a variable-latency memory with a req/ack handshake, and returns read data with a one-cycle ready pulse. A watchdog aborts transactions the memory never acknowledges.

## Interface
- DATA_WIDTH, 32, data and address width
- TIMEOUT, 255, max cycles in BUSY before abort (1..255)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  DATA_WIDTH  fetch address (word read)
- if_ready  out  1  one-cycle completion pulse
- if_rdata  out  DATA_WIDTH  fetched word, valid with if_ready
- if_err  out  1  timeout flag, valid with if_ready
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr, d_wdata  in  DATA_WIDTH  address / store data
- d_maskmode  in  2  funct3[1:0] size (byte/half/word)
- d_sext  in  1  funct3[2]; 1 = zero-extend
- d_ready  out  1  one-cycle completion pulse
- d_rdata  out  DATA_WIDTH  load data; 0 for stores
- d_err  out  1  timeout flag, valid with d_ready
- mem_req  out  1  memory request, high throughout BUSY
- mem_we, mem_addr, mem_wdata, mem_maskmode, mem_sext  out  —  latched request fields
- mem_ack  in  1  memory completion, one cycle
- mem_rdata  in  DATA_WIDTH  valid with mem_ack

## Operation
- States: IDLE, BUSY, RESP. Register owner (IF/D) and last_grant (IF/D).
- IDLE: if exactly one req high, grant it; if both, grant the side != last_grant. On grant: latch fields (fetch: we=0, maskmode=2'b10, sext=0), owner/last_grant <= grantee, wd_cnt <= 0, -> BUSY.
- BUSY: mem_req=1, mem_* driven from latches (stable whole state). On mem_ack: capture mem_rdata (0 if store) into owner's rdata register, err=0, -> RESP. Else wd_cnt++; when wd_cnt reaches TIMEOUT-1 without ack: rdata=0, err=1, -> RESP.
- RESP: owner's ready=1 for exactly this cycle; -> IDLE. No grant in RESP.
- mem_ack outside BUSY ignored. Requester req changes during BUSY/RESP ignored (fields latched).
- Requester drops req in the cycle after its ready, or keeps it high to present a new request; IDLE treats any high req as new.
- if_rdata/d_rdata/err hold last value between pulses.

## Timing
- Reset: state IDLE, last_grant=IF (first tie goes to D), all outputs 0, rdata registers 0, wd_cnt 0. Reset mid-BUSY drops mem_req next edge; transaction lost, no ready.
- Latency: req sampled in IDLE cycle n -> mem_req cycle n+1; ack at cycle n+k (k>=1) -> ready at n+k+1. Minimum 3 cycles req-to-next-grant per transaction.
- Timeout: no ack in TIMEOUT BUSY cycles -> ready+err in cycle n+TIMEOUT+1.
- Ack in same cycle as watchdog expiry: ack wins, err=0.
- Back-to-back: with both reqs held continuously, grants strictly alternate IF, D, IF...

## Structure
- Package mem_arb_pkg: state enum (IDLE/BUSY/RESP), owner encoding (OWN_IF=0, OWN_D=1), fetch maskmode constant 2'b10.
- Sub-module mem_arb_watchdog: 8-bit counter with clear/enable, expire output at TIMEOUT-1.

## Test plan
- Single fetch: if_req, if_addr=0x10, memory acks after 2 cycles with 0x00500093 -> mem_req 2 cycles, if_ready one pulse at cycle 4, if_rdata=0x00500093, if_err=0.
- Tie after reset: both req same cycle -> D granted first (mem_we=d_we, mem_addr=d_addr), then IF; sustained both -> alternating grants.
- Store: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, maskmode=2'b00 -> mem_* carry those values, d_ready pulse, d_rdata=0.
- Timeout: TIMEOUT=4, no ack -> d_ready+d_err at grant+5, then IDLE and IF served next.
- Reset mid-BUSY: rst high while mem_req=1 -> next cycle mem_req=0, no ready pulse, state IDLE.
- Ack outside BUSY and field change during BUSY: stray mem_ack in IDLE ignored; changing d_addr mid-BUSY leaves mem_addr unchanged.
